bus_bridge_uart_framer: RTL and testbench



---
 rtl/bus_bridge_uart_framer_pkg.sv | 33 +++
 rtl/bus_bridge_uart_framer_if.sv | 39 +++
 rtl/bus_bridge_uart_framer_req_fifo.sv | 54 +++++
 rtl/bus_bridge_uart_framer.sv | 239 +++++++++++++++++++++++
 tb/tb_bus_bridge_uart_framer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_bridge_uart_framer_pkg.sv
// Shared types and constants for the UART framing engine on the bus bridge initiator path.
package bus_bridge_uart_framer_pkg;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_ADDR,
    RX_DATA,
    RX_FLAGS,
    RX_CSUM
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_STATUS,
    TX_DATA,
    TX_CSUM
  } tx_state_e;

  typedef enum logic [1:0] {
    ERR_CSUM     = 2'd0,
    ERR_FLAGS    = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_bridge_uart_framer_if.sv
// Byte UART, bridge request/response and error-report signals of the framer.
interface bus_bridge_uart_framer_if
  import bus_bridge_uart_framer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_write;
  logic                  frame_err;
  logic [1:0]            err_code;
  logic [7:0]            err_count;

  modport slave (
    input  rx_valid, rx_data, tx_ready, req_ready, resp_valid, resp_rdata, resp_write,
    output tx_valid, tx_data, req_valid, req_addr, req_wdata, req_write, resp_ready,
           frame_err, err_code, err_count
  );

  modport master (
    output rx_valid, rx_data, tx_ready, req_ready, resp_valid, resp_rdata, resp_write,
    input  tx_valid, tx_data, req_valid, req_addr, req_wdata, req_write, resp_ready,
           frame_err, err_code, err_count
  );

endinterface

// File: rtl/bus_bridge_uart_framer_req_fifo.sv
// Synchronous show-ahead request FIFO; the head entry is visible whenever not empty.
module bus_bridge_req_fifo
  import bus_bridge_uart_framer_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge_uart_framer.sv
// UART framing engine: parses checksummed request frames into a FIFO and serialises responses.
module bus_bridge_uart_framer
  import bus_bridge_uart_framer_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_WIDTH     = 8,
  parameter int         REQ_DEPTH      = 4,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   rst,
  bus_bridge_uart_framer_if.slave bus
);

  localparam int         AB        = ADDR_WIDTH / 8;
  localparam int         DB        = DATA_WIDTH / 8;
  localparam int         FW        = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int         IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] AB_LAST   = 8'(AB - 1);
  localparam logic [7:0] DB_LAST   = 8'(DB - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] fold_xor(input logic [DATA_WIDTH-1:0] d);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < DB; i++) acc ^= d[8*i +: 8];
    return acc;
  endfunction

  rx_state_e             r_rx_state, w_rx_next;
  logic [7:0]            r_rx_cnt;
  logic [ADDR_WIDTH-1:0] r_rx_addr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [7:0]            r_rx_flags;
  logic [7:0]            r_rx_csum;
  logic [IW-1:0]         r_idle;
  logic                  w_push;
  logic                  w_err;
  err_code_e             w_err_code;
  logic                  r_frame_err;
  err_code_e             r_err_code;
  logic [7:0]            r_err_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_pop;
  logic [FW-1:0]         w_fifo_head;

  // RX next-state and frame verdict
  always_comb begin
    w_rx_next  = r_rx_state;
    w_push     = 1'b0;
    w_err      = 1'b0;
    w_err_code = ERR_CSUM;
    if (bus.rx_valid) begin
      case (r_rx_state)
        RX_HUNT:  if (bus.rx_data == SYNC_BYTE) w_rx_next = RX_ADDR;
        RX_ADDR:  if (r_rx_cnt == AB_LAST) w_rx_next = RX_DATA;
        RX_DATA:  if (r_rx_cnt == DB_LAST) w_rx_next = RX_FLAGS;
        RX_FLAGS: w_rx_next = RX_CSUM;
        RX_CSUM: begin
          w_rx_next = RX_HUNT;
          if (r_rx_flags[7:1] != 7'd0) begin
            w_err      = 1'b1;
            w_err_code = ERR_FLAGS;
          end else if (bus.rx_data != r_rx_csum) begin
            w_err      = 1'b1;
            w_err_code = ERR_CSUM;
          end else if (w_fifo_full) begin
            w_err      = 1'b1;
            w_err_code = ERR_OVERFLOW;
          end else begin
            w_push = 1'b1;
          end
        end
        default:  w_rx_next = RX_HUNT;
      endcase
    end else if (r_rx_state != RX_HUNT && r_idle == IDLE_LAST) begin
      // An arriving byte takes precedence, so expiry is only considered on idle cycles.
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
      w_rx_next  = RX_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rx_valid) begin
      case (r_rx_state)
        RX_HUNT: begin
          r_rx_cnt  <= '0;
          r_rx_csum <= '0;
        end
        RX_ADDR: begin
          r_rx_addr[8*r_rx_cnt +: 8] <= bus.rx_data;
          r_rx_csum <= r_rx_csum ^ bus.rx_data;
          r_rx_cnt  <= (r_rx_cnt == AB_LAST) ? 8'd0 : r_rx_cnt + 8'd1;
        end
        RX_DATA: begin
          r_rx_data[8*r_rx_cnt +: 8] <= bus.rx_data;
          r_rx_csum <= r_rx_csum ^ bus.rx_data;
          r_rx_cnt  <= (r_rx_cnt == DB_LAST) ? 8'd0 : r_rx_cnt + 8'd1;
        end
        RX_FLAGS: begin
          r_rx_flags <= bus.rx_data;
          r_rx_csum  <= r_rx_csum ^ bus.rx_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state  <= RX_HUNT;
      r_idle      <= '0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_CSUM;
      r_err_count <= '0;
    end else begin
      r_rx_state  <= w_rx_next;
      r_idle      <= (bus.rx_valid || r_rx_state == RX_HUNT) ? '0 : r_idle + IW'(1);
      r_frame_err <= w_err;
      r_err_code  <= w_err ? w_err_code : ERR_CSUM;
      if (w_err) r_err_count <= sat_inc8(r_err_count);
    end
  end

  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
  assign bus.err_count = r_err_count;

  // Request FIFO boundary
  assign w_pop = bus.req_ready && !w_fifo_empty;

  bus_bridge_req_fifo #(
    .WIDTH (FW),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({r_rx_addr, r_rx_data, r_rx_flags[0]}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Storage is not reset, so the head is masked to keep req_* at zero while empty.
  assign bus.req_valid = !w_fifo_empty;
  assign {bus.req_addr, bus.req_wdata, bus.req_write} = w_fifo_empty ? '0 : w_fifo_head;

  tx_state_e             r_tx_state, w_tx_next;
  logic                  r_tx_valid, w_tx_valid;
  logic [7:0]            r_tx_data, w_tx_data;
  logic [7:0]            r_tx_cnt, w_tx_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift;
  logic [7:0]            r_tx_csum;
  logic                  r_resp_write;
  logic                  r_resp_ready;
  logic                  w_tx_acc;
  logic                  w_capture;

  assign w_tx_acc = r_tx_valid && bus.tx_ready;

  // TX next-state and next presented byte
  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_valid = r_tx_valid;
    w_tx_data  = r_tx_data;
    w_tx_cnt   = r_tx_cnt;
    w_tx_shift = r_tx_shift;
    w_capture  = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (bus.resp_valid && r_resp_ready) begin
        w_capture  = 1'b1;
        w_tx_next  = TX_SYNC;
        w_tx_valid = 1'b1;
        w_tx_data  = SYNC_BYTE;
        w_tx_shift = bus.resp_rdata;
      end
      TX_SYNC: if (w_tx_acc) begin
        w_tx_next = TX_STATUS;
        w_tx_data = {7'b0, r_resp_write};
      end
      TX_STATUS: if (w_tx_acc) begin
        w_tx_next  = TX_DATA;
        w_tx_cnt   = '0;
        w_tx_data  = r_tx_shift[7:0];
        w_tx_shift = r_tx_shift >> 8;
      end
      TX_DATA: if (w_tx_acc) begin
        if (r_tx_cnt == DB_LAST) begin
          w_tx_next = TX_CSUM;
          w_tx_data = r_tx_csum;
        end else begin
          w_tx_cnt   = r_tx_cnt + 8'd1;
          w_tx_data  = r_tx_shift[7:0];
          w_tx_shift = r_tx_shift >> 8;
        end
      end
      TX_CSUM: if (w_tx_acc) begin
        w_tx_next  = TX_IDLE;
        w_tx_valid = 1'b0;
        w_tx_data  = '0;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift;
    if (w_capture) begin
      r_resp_write <= bus.resp_write;
      r_tx_csum    <= fold_xor(bus.resp_rdata) ^ {7'b0, bus.resp_write};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state   <= TX_IDLE;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_cnt     <= '0;
      r_resp_ready <= 1'b0;
    end else begin
      r_tx_state   <= w_tx_next;
      r_tx_valid   <= w_tx_valid;
      r_tx_data    <= w_tx_data;
      r_tx_cnt     <= w_tx_cnt;
      r_resp_ready <= (w_tx_next == TX_IDLE);
    end
  end

  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.resp_ready = r_resp_ready;

endmodule

// File: tb/tb_bus_bridge_uart_framer.sv
// Randomised bench for the UART framer against a frame-level reference model (two geometries).
module tb_bus_bridge_uart_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_bridge_uart_framer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  b0 ();
  bus_bridge_uart_framer_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) b1 ();

  bus_bridge_uart_framer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .REQ_DEPTH(4),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  bus_bridge_uart_framer #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .REQ_DEPTH(4),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int errors = 0;
  int checks = 0;
  int exp_errs = 0;
  logic [7:0]  fq[$];
  logic [24:0] q0[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs0();
    return 64'({b0.tx_valid, b0.tx_data, b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write,
                b0.resp_ready, b0.frame_err, b0.err_code, b0.err_count});
  endfunction

  function automatic logic [63:0] outs1();
    return {1'b0, b1.tx_valid, b1.tx_data, b1.req_valid, b1.req_addr, b1.req_wdata, b1.req_write,
            b1.resp_ready, b1.frame_err, b1.err_code, b1.err_count};
  endfunction

  // Frame model: SYNC, address LSB first, data LSB first, flags, XOR of everything after SYNC.
  function automatic void build_frame(input logic [23:0] a, input logic [15:0] d,
                                      input logic [7:0] flags, input int ab, input int db);
    logic [7:0] cs;
    cs = 8'h00;
    fq.delete();
    fq.push_back(8'hA5);
    for (int i = 0; i < ab; i++) begin fq.push_back(a[8*i +: 8]); cs ^= a[8*i +: 8]; end
    for (int i = 0; i < db; i++) begin fq.push_back(d[8*i +: 8]); cs ^= d[8*i +: 8]; end
    fq.push_back(flags);
    cs ^= flags;
    fq.push_back(cs);
  endfunction

  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (sel) begin b1.rx_valid = 1'b1; b1.rx_data = b; end
    else begin b0.rx_valid = 1'b1; b0.rx_data = b; end
    tick();
    b0.rx_valid = 1'b0;
    b1.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit sel);
    foreach (fq[i]) send_byte(sel, fq[i]);
  endtask

  function automatic void note_err();
    exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    b0.rx_valid = 0; b0.rx_data = 0; b0.tx_ready = 0; b0.req_ready = 0;
    b0.resp_valid = 0; b0.resp_rdata = 0; b0.resp_write = 0;
    b1.rx_valid = 0; b1.rx_data = 0; b1.tx_ready = 0; b1.req_ready = 0;
    b1.resp_valid = 0; b1.resp_rdata = 0; b1.resp_write = 0;
    repeat (3) tick();
    checks++; if (outs0() !== 64'd0) begin errors++; $display("FAIL reset_outs0: got %h want 0", outs0()); end
    checks++; if (outs1() !== 64'd0) begin errors++; $display("FAIL reset_outs1: got %h want 0", outs1()); end
    rst = 1'b0;
    tick();
    checks++; if (b0.resp_ready !== 1'b1) begin errors++; $display("FAIL reset_resp_ready: got %b want 1", b0.resp_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] f[6];
    f = '{8'hA5, 8'h34, 8'h12, 8'h5C, 8'h01, 8'h7B};
    for (int i = 0; i < 5; i++) send_byte(0, f[i]);
    checks++; if (b0.req_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", b0.req_valid); end
    send_byte(0, f[5]);
    checks++; if (b0.req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %b want 1", b0.req_valid); end
    checks++; if ({b0.req_addr, b0.req_wdata, b0.req_write} !== {16'h1234, 8'h5C, 1'b1}) begin
      errors++; $display("FAIL basic_head: got %h/%h/%b want 1234/5c/1", b0.req_addr, b0.req_wdata, b0.req_write); end
    checks++; if (b0.frame_err !== 1'b0) begin errors++; $display("FAIL basic_no_err: got %b want 0", b0.frame_err); end
    b0.req_ready = 1'b1; tick(); b0.req_ready = 1'b0;
    checks++; if (b0.req_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b want 0", b0.req_valid); end
  endtask

  task automatic test_csum_err();
    logic [7:0] f[6];
    logic [23:0] a; logic [15:0] d; logic wr;
    f = '{8'hA5, 8'h34, 8'h12, 8'h5C, 8'h01, 8'h00};
    foreach (f[i]) send_byte(0, f[i]);
    note_err();
    checks++; if (b0.frame_err !== 1'b1 || b0.err_code !== 2'd0) begin
      errors++; $display("FAIL csum_err_pulse: got err=%b code=%0d want err=1 code=0", b0.frame_err, b0.err_code); end
    checks++; if (b0.err_count !== 8'(exp_errs)) begin errors++; $display("FAIL csum_err_count: got %0d want %0d", b0.err_count, exp_errs); end
    checks++; if (b0.req_valid !== 1'b0) begin errors++; $display("FAIL csum_err_nopush: got %b want 0", b0.req_valid); end
    tick();
    checks++; if (b0.frame_err !== 1'b0) begin errors++; $display("FAIL csum_err_one_cycle: got %b want 0", b0.frame_err); end
    a = 24'($urandom); d = 16'($urandom); wr = 1'($urandom);
    build_frame(a, d, {7'b0, wr}, 2, 1);
    send_frame(0);
    checks++; if ({b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write} !== {1'b1, a[15:0], d[7:0], wr}) begin
      errors++; $display("FAIL csum_err_recover: got %b/%h/%h/%b want 1/%h/%h/%b",
        b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write, a[15:0], d[7:0], wr); end
    b0.req_ready = 1'b1; tick(); b0.req_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    logic [23:0] a; logic [15:0] d; logic wr;
    send_byte(0, 8'h00);
    checks++; if (b0.frame_err !== 1'b0) begin errors++; $display("FAIL stray_00: got %b want 0", b0.frame_err); end
    send_byte(0, 8'hFF);
    checks++; if (b0.frame_err !== 1'b0) begin errors++; $display("FAIL stray_ff: got %b want 0", b0.frame_err); end
    send_byte(0, 8'hA5);
    send_byte(0, 8'h34);
    k = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (b0.frame_err === 1'b1) begin k = n; break; end
    end
    note_err();
    checks++; if (k != 100) begin errors++; $display("FAIL timeout_cycles: got %0d want 100", k); end
    checks++; if (b0.err_code !== 2'd2) begin errors++; $display("FAIL timeout_code: got %0d want 2", b0.err_code); end
    checks++; if (b0.err_count !== 8'(exp_errs)) begin errors++; $display("FAIL timeout_count: got %0d want %0d", b0.err_count, exp_errs); end
    a = 24'($urandom); d = 16'($urandom); wr = 1'($urandom);
    build_frame(a, d, {7'b0, wr}, 2, 1);
    send_frame(0);
    checks++; if ({b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write} !== {1'b1, a[15:0], d[7:0], wr}) begin
      errors++; $display("FAIL timeout_recover: got %b/%h/%h want 1/%h/%h", b0.req_valid, b0.req_addr, b0.req_wdata, a[15:0], d[7:0]); end
    b0.req_ready = 1'b1; tick(); b0.req_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [23:0] a; logic [15:0] d; logic wr;
    b0.req_ready = 1'b0;
    q0.delete();
    for (int i = 0; i < 5; i++) begin
      a = 24'($urandom); d = 16'($urandom); wr = 1'($urandom);
      build_frame(a, d, {7'b0, wr}, 2, 1);
      send_frame(0);
      if (q0.size() < 4) q0.push_back({a[15:0], d[7:0], wr});
      else note_err();
      checks++; if (b0.frame_err !== (i == 4)) begin errors++; $display("FAIL overflow_err_%0d: got %b want %b", i, b0.frame_err, i == 4); end
    end
    checks++; if (b0.err_code !== 2'd3) begin errors++; $display("FAIL overflow_code: got %0d want 3", b0.err_code); end
    checks++; if (b0.err_count !== 8'(exp_errs)) begin errors++; $display("FAIL overflow_count: got %0d want %0d", b0.err_count, exp_errs); end
    b0.req_ready = 1'b1;
    foreach (q0[n]) begin
      checks++; if ({b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write} !== {1'b1, q0[n]}) begin
        errors++; $display("FAIL overflow_pop_%0d: got %b/%h want 1/%h", n, b0.req_valid,
          {b0.req_addr, b0.req_wdata, b0.req_write}, q0[n]); end
      tick();
    end
    b0.req_ready = 1'b0;
    checks++; if (b0.req_valid !== 1'b0) begin errors++; $display("FAIL overflow_drained: got %b want 0", b0.req_valid); end
  endtask

  task automatic test_random();
    logic [23:0] a; logic [15:0] d; logic wr; logic [7:0] flags;
    int kind; bit bad_fl, bad_cs;
    for (int it = 0; it < 12; it++) begin
      kind = int'($urandom_range(0, 3));
      bad_fl = (kind >= 2); bad_cs = (kind % 2 == 1);
      a = 24'($urandom); d = 16'($urandom); wr = 1'($urandom);
      flags = {7'b0, wr};
      if (bad_fl) flags = flags | (8'($urandom_range(1, 127)) << 1);
      build_frame(a, d, flags, 2, 1);
      if (bad_cs) fq[fq.size()-1] = fq[fq.size()-1] ^ 8'($urandom_range(1, 255));
      send_frame(0);
      checks++; if (b0.frame_err !== (bad_fl || bad_cs)) begin
        errors++; $display("FAIL random_err_%0d: got %b want %b", it, b0.frame_err, bad_fl || bad_cs); end
      if (bad_fl || bad_cs) begin
        note_err();
        checks++; if (b0.err_code !== (bad_fl ? 2'd1 : 2'd0)) begin
          errors++; $display("FAIL random_code_%0d: got %0d want %0d", it, b0.err_code, bad_fl ? 1 : 0); end
        checks++; if (b0.err_count !== 8'(exp_errs)) begin
          errors++; $display("FAIL random_count_%0d: got %0d want %0d", it, b0.err_count, exp_errs); end
      end else begin
        checks++; if ({b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write} !== {1'b1, a[15:0], d[7:0], wr}) begin
          errors++; $display("FAIL random_head_%0d: got %b/%h/%h/%b want 1/%h/%h/%b", it, b0.req_valid,
            b0.req_addr, b0.req_wdata, b0.req_write, a[15:0], d[7:0], wr); end
        b0.req_ready = 1'b1; tick(); b0.req_ready = 1'b0;
      end
    end
  endtask

  task automatic read_tx(input bit sel, output logic tv, output logic [7:0] td, output logic rr);
    tv = sel ? b1.tx_valid : b0.tx_valid;
    td = sel ? b1.tx_data : b0.tx_data;
    rr = sel ? b1.resp_ready : b0.resp_ready;
  endtask

  task automatic do_tx(input bit sel, input logic [15:0] rd, input logic wr, input int db);
    logic [7:0] exp_b[$], got[$];
    logic [7:0] cs, td, pend_d;
    logic tv, rr, tr, pend;
    int n;
    cs = {7'b0, wr};
    exp_b.push_back(8'hA5);
    exp_b.push_back({7'b0, wr});
    for (int i = 0; i < db; i++) begin exp_b.push_back(rd[8*i +: 8]); cs ^= rd[8*i +: 8]; end
    exp_b.push_back(cs);
    if (sel) begin b1.resp_valid = 1'b1; b1.resp_rdata = rd; b1.resp_write = wr; end
    else begin b0.resp_valid = 1'b1; b0.resp_rdata = rd[7:0]; b0.resp_write = wr; end
    read_tx(sel, tv, td, rr);
    for (n = 0; n < 50 && rr !== 1'b1; n++) begin tick(); read_tx(sel, tv, td, rr); end
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL tx_resp_ready_wait: got %b want 1", rr); end
    tick();
    b0.resp_valid = 1'b0; b1.resp_valid = 1'b0;
    read_tx(sel, tv, td, rr);
    checks++; if (tv !== 1'b1 || td !== 8'hA5) begin errors++; $display("FAIL tx_first_sync: got %b/%h want 1/a5", tv, td); end
    pend = 1'b0; pend_d = 8'h00;
    for (n = 0; n < 400 && got.size() < exp_b.size(); n++) begin
      read_tx(sel, tv, td, rr);
      if (pend) begin
        checks++; if (tv !== 1'b1 || td !== pend_d) begin errors++; $display("FAIL tx_hold: got %b/%h want 1/%h", tv, td, pend_d); end
      end
      checks++; if (rr !== 1'b0) begin errors++; $display("FAIL tx_resp_ready_busy: got %b want 0", rr); end
      tr = 1'($urandom);
      if (sel) b1.tx_ready = tr; else b0.tx_ready = tr;
      tick();
      if (tv === 1'b1 && tr) begin got.push_back(td); pend = 1'b0; end
      else begin pend = (tv === 1'b1); pend_d = td; end
    end
    b0.tx_ready = 1'b0; b1.tx_ready = 1'b0;
    read_tx(sel, tv, td, rr);
    checks++; if (got.size() != exp_b.size()) begin errors++; $display("FAIL tx_byte_count: got %0d want %0d", got.size(), exp_b.size()); end
    checks++; if (rr !== 1'b1 || tv !== 1'b0) begin errors++; $display("FAIL tx_done: got ready=%b valid=%b want 1/0", rr, tv); end
    foreach (exp_b[i]) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL tx_byte_%0d: got %h want %h", i, got[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_tx();
    do_tx(0, 16'h003C, 1'b0, 1);
    for (int i = 0; i < 2; i++) do_tx(0, 16'($urandom) & 16'h00FF, 1'($urandom), 1);
  endtask

  task automatic test_wide();
    logic [7:0] f[8];
    f = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hCD, 8'hAB, 8'h00, 8'h66};
    foreach (f[i]) send_byte(1, f[i]);
    checks++; if ({b1.req_valid, b1.req_addr, b1.req_wdata, b1.req_write} !== {1'b1, 24'h030201, 16'hABCD, 1'b0}) begin
      errors++; $display("FAIL wide_head: got %b/%h/%h/%b want 1/030201/abcd/0", b1.req_valid, b1.req_addr, b1.req_wdata, b1.req_write); end
    b1.req_ready = 1'b1; tick(); b1.req_ready = 1'b0;
    do_tx(1, 16'($urandom), 1'($urandom), 2);
  endtask

  task automatic test_reset_mid();
    logic [23:0] a; logic [15:0] d; logic wr;
    send_byte(0, 8'hA5);
    send_byte(0, 8'h34);
    b0.resp_valid = 1'b1; b0.resp_rdata = 8'h77; b0.resp_write = 1'b1; b0.tx_ready = 1'b0;
    tick();
    b0.resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (outs0() !== 64'd0) begin errors++; $display("FAIL midreset_outs0: got %h want 0", outs0()); end
    checks++; if (outs1() !== 64'd0) begin errors++; $display("FAIL midreset_outs1: got %h want 0", outs1()); end
    tick();
    rst = 1'b0;
    exp_errs = 0;
    tick();
    checks++; if (b0.tx_valid !== 1'b0 || b0.resp_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_tx_idle: got valid=%b ready=%b want 0/1", b0.tx_valid, b0.resp_ready); end
    a = 24'($urandom); d = 16'($urandom); wr = 1'($urandom);
    build_frame(a, d, {7'b0, wr}, 2, 1);
    send_frame(0);
    checks++; if ({b0.req_valid, b0.req_addr, b0.req_wdata, b0.req_write, b0.frame_err} !== {1'b1, a[15:0], d[7:0], wr, 1'b0}) begin
      errors++; $display("FAIL midreset_next_frame: got %b/%h/%h/%b err=%b want 1/%h/%h/%b err=0", b0.req_valid,
        b0.req_addr, b0.req_wdata, b0.req_write, b0.frame_err, a[15:0], d[7:0], wr); end
    b0.req_ready = 1'b1; tick(); b0.req_ready = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      build_frame(24'h0, 16'h0, 8'h00, 2, 1);
      fq[fq.size()-1] = 8'hFF;
      send_frame(0);
      note_err();
    end
    checks++; if (b0.frame_err !== 1'b1) begin errors++; $display("FAIL saturate_pulse: got %b want 1", b0.frame_err); end
    checks++; if (b0.err_count !== 8'(exp_errs)) begin errors++; $display("FAIL saturate_count: got %0d want %0d", b0.err_count, exp_errs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_err();
    test_timeout();
    test_overflow();
    test_random();
    test_tx();
    test_wide();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
